// File: rtl/egress_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : egress_arbiter
// Brief    : Frame-granular round-robin arbiter merging NUM_PORTS AXI-stream
//            ingress ports onto one egress port, with an Avalon-MM register
//            slave. Define EGRESS_ARBITER_STATS_EN for per-port frame counters.
// Revision : 1.0 - initial release
// ============================================================================
module egress_arbiter #(
    parameter int NUM_PORTS = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [7:0]                writedata,
    input  logic                      write,
    input  logic                      chipselect,
    input  logic [7:0]                address,
    input  logic                      read,
    output logic [7:0]                readdata,
    input  logic [16*NUM_PORTS-1:0]   ingress_port_tdata,
    input  logic [NUM_PORTS-1:0]      ingress_port_tvalid,
    input  logic [NUM_PORTS-1:0]      ingress_port_tlast,
    output logic [NUM_PORTS-1:0]      ingress_port_tready,
    output logic [15:0]               egress_port_tdata,
    output logic                      egress_port_tlast,
    output logic                      egress_port_tvalid,
    input  logic                      egress_port_tready
);

    localparam int              c_GW         = (NUM_PORTS > 2) ? 2 : 1;
    localparam logic [0:0]      c_S_IDLE     = 1'b0;
    localparam logic [0:0]      c_S_GRANT    = 1'b1;
    localparam logic [c_GW-1:0] c_LAST_RESET = c_GW'(NUM_PORTS - 1);

    logic [0:0]           r_state;
    logic [c_GW-1:0]      r_grant;
    logic [NUM_PORTS-1:0] r_enable;
    logic [7:0]           r_readdata;

    logic [15:0]          w_port_data [NUM_PORTS];
    logic                 w_in_grant;
    logic                 w_sel_valid;
    logic                 w_sel_last;
    logic [15:0]          w_sel_data;
    logic                 w_accept_last;
    logic [NUM_PORTS-1:0] w_req;
    logic                 w_found;
    logic [c_GW-1:0]      w_next_grant;
    logic                 w_wr;
    logic                 w_rd;
    logic [7:0]           w_rdata;
    logic                 w_unused;

    generate
        for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_unpack
            assign w_port_data[gi] = ingress_port_tdata[16*gi +: 16];
        end
    endgenerate

    // r_grant doubles as last_grant while idle.
    assign w_in_grant    = (r_state == c_S_GRANT);
    assign w_sel_valid   = ingress_port_tvalid[r_grant];
    assign w_sel_last    = ingress_port_tlast[r_grant];
    assign w_sel_data    = w_port_data[r_grant];
    assign w_accept_last = w_in_grant && w_sel_valid && w_sel_last && egress_port_tready;

    assign egress_port_tvalid = w_in_grant & w_sel_valid;
    assign egress_port_tlast  = w_in_grant & w_sel_last;
    assign egress_port_tdata  = w_in_grant ? w_sel_data : 16'h0000;

    always_comb begin
        ingress_port_tready = '0;
        if (w_in_grant) begin
            ingress_port_tready[r_grant] = egress_port_tready;
        end
    end

    assign w_req = ingress_port_tvalid & r_enable;

    // Scan offsets from farthest to nearest so the nearest requester after
    // the last grant is the final (winning) assignment.
    always_comb begin
        w_found      = 1'b0;
        w_next_grant = r_grant;
        for (int k = NUM_PORTS; k >= 1; k--) begin
            for (int i = 0; i < NUM_PORTS; i++) begin
                if (w_req[i] && (((int'(r_grant) + k) % NUM_PORTS) == i)) begin
                    w_found      = 1'b1;
                    w_next_grant = c_GW'(i);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= c_S_IDLE;
            r_grant <= c_LAST_RESET;
        end else begin
            case (r_state)
                c_S_IDLE: begin
                    if (w_found) begin
                        r_grant <= w_next_grant;
                        r_state <= c_S_GRANT;
                    end
                end
                c_S_GRANT: begin
                    if (w_accept_last) begin
                        r_state <= c_S_IDLE;
                    end
                end
                default: r_state <= c_S_IDLE;
            endcase
        end
    end

    assign w_wr = chipselect & write;
    assign w_rd = chipselect & read;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_enable <= '1;
        end else if (w_wr && (address == 8'h00)) begin
            r_enable <= writedata[NUM_PORTS-1:0];
        end
    end

`ifdef EGRESS_ARBITER_STATS_EN
    logic [7:0] r_cnt [NUM_PORTS];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_PORTS; i++) begin
                r_cnt[i] <= 8'h00;
            end
        end else if (w_wr && (address == 8'h08)) begin
            for (int i = 0; i < NUM_PORTS; i++) begin
                r_cnt[i] <= 8'h00;
            end
        end else if (w_accept_last) begin
            r_cnt[r_grant] <= r_cnt[r_grant] + 8'h01;
        end
    end
`endif

    always_comb begin
        w_rdata = 8'h00;
        case (address)
            8'h00: w_rdata[NUM_PORTS-1:0] = r_enable;
            8'h01: begin
                w_rdata[7]      = r_state[0];
                w_rdata[c_GW-1:0] = r_grant;
            end
            default: w_rdata = 8'h00;
        endcase
`ifdef EGRESS_ARBITER_STATS_EN
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (address == 8'(4 + i)) begin
                w_rdata = r_cnt[i];
            end
        end
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_readdata <= 8'h00;
        end else begin
            r_readdata <= w_rd ? w_rdata : 8'h00;
        end
    end

    assign readdata = r_readdata;

    // Upper write-data bits are architecturally ignored.
    assign w_unused = ^writedata;

endmodule
`default_nettype wire

// File: tb/tb_egress_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_egress_arbiter
// Brief    : Directed scoreboard bench for egress_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_egress_arbiter;

    localparam int NP = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic [7:0]        writedata;
    logic              write;
    logic              chipselect;
    logic [7:0]        address;
    logic              read;
    logic [7:0]        readdata;
    logic [16*NP-1:0]  ingress_port_tdata;
    logic [NP-1:0]     ingress_port_tvalid;
    logic [NP-1:0]     ingress_port_tlast;
    logic [NP-1:0]     ingress_port_tready;
    logic [15:0]       egress_port_tdata;
    logic              egress_port_tlast;
    logic              egress_port_tvalid;
    logic              egress_port_tready;

    always #5 clk = ~clk;

    egress_arbiter #(.NUM_PORTS(NP)) dut (
        .clk                 (clk),
        .reset               (reset),
        .writedata           (writedata),
        .write               (write),
        .chipselect          (chipselect),
        .address             (address),
        .read                (read),
        .readdata            (readdata),
        .ingress_port_tdata  (ingress_port_tdata),
        .ingress_port_tvalid (ingress_port_tvalid),
        .ingress_port_tlast  (ingress_port_tlast),
        .ingress_port_tready (ingress_port_tready),
        .egress_port_tdata   (egress_port_tdata),
        .egress_port_tlast   (egress_port_tlast),
        .egress_port_tvalid  (egress_port_tvalid),
        .egress_port_tready  (egress_port_tready)
    );

    // Beat encoding: {tlast, port[3:0], frame[3:0], beat[7:0]}
    logic [16:0]   src_q [NP][$];
    logic [16:0]   sb [$];
    logic [NP-1:0] src_pause;
    logic          toggle_rdy;
    logic          s_evalid;
    logic [NP-1:0] s_tready;
    int            n_checks = 0;
    int            n_errors = 0;
    int            cyc;

    function automatic logic [16:0] mk(input int port, input int frame, input int beat, input bit last);
        return {last, 4'(port), 4'(frame), 8'(beat)};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic add_frame(input int port, input int frame, input int nbeats, input bit expect_it);
        logic [16:0] v;
        for (int b = 0; b < nbeats; b++) begin
            v = mk(port, frame, b, (b == nbeats - 1));
            src_q[port].push_back(v);
            if (expect_it) sb.push_back(v);
        end
    endtask

    task automatic drive();
        logic [16:0] h;
        for (int i = 0; i < NP; i++) begin
            if (src_q[i].size() > 0 && !src_pause[i]) begin
                h = src_q[i][0];
                ingress_port_tvalid[i]        = 1'b1;
                ingress_port_tlast[i]         = h[16];
                ingress_port_tdata[16*i +: 16] = h[15:0];
            end else begin
                ingress_port_tvalid[i]        = 1'b0;
                ingress_port_tlast[i]         = 1'b0;
                ingress_port_tdata[16*i +: 16] = 16'h0000;
            end
        end
        egress_port_tready = toggle_rdy ? ~egress_port_tready : 1'b1;
    endtask

    // One clock: drive after negedge, sample 1ns later, advance sources
    // once the edge has consumed the handshakes.
    task automatic tick();
        logic [NP-1:0] pop;
        logic [16:0]   e;
        drive();
        #1;
        s_evalid = egress_port_tvalid;
        s_tready = ingress_port_tready;
        chk("tready_onehot0", 32'($onehot0(ingress_port_tready)), 32'd1);
        pop = ingress_port_tvalid & ingress_port_tready;
        if (egress_port_tvalid && egress_port_tready) begin
            chk("beat_expected", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("egress_beat", 32'({egress_port_tlast, egress_port_tdata}), 32'(e));
                chk("tready_sel", 32'(ingress_port_tready), 32'd1 << e[15:12]);
            end
        end
        @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < NP; i++) begin
            if (pop[i]) void'(src_q[i].pop_front());
        end
    endtask

    task automatic run_until_empty(input string tag, input int max, output int cycles);
        cycles = 0;
        while (sb.size() != 0 && cycles < max) begin
            tick();
            cycles++;
        end
        chk({"drain_", tag}, 32'(sb.size()), 32'd0);
    endtask

    task automatic av_write(input logic [7:0] a, input logic [7:0] d);
        chipselect = 1'b1; write = 1'b1; address = a; writedata = d;
        tick();
        chipselect = 1'b0; write = 1'b0;
    endtask

    task automatic av_read(input string tag, input logic [7:0] a, input logic [7:0] exp);
        chipselect = 1'b1; read = 1'b1; address = a;
        tick();
        chipselect = 1'b0; read = 1'b0;
        chk(tag, 32'(readdata), 32'(exp));
    endtask

    initial begin
        #200_000;
        $display("FAIL watchdog: simulation did not complete, observed timeout expected finish");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; writedata = '0; write = 1'b0; chipselect = 1'b0;
        address = '0; read = 1'b0; ingress_port_tdata = '0;
        ingress_port_tvalid = '0; ingress_port_tlast = '0;
        egress_port_tready = 1'b1; toggle_rdy = 1'b0; src_pause = '0;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_evalid", 32'(egress_port_tvalid), 32'd0);
        chk("rst_elast", 32'(egress_port_tlast), 32'd0);
        chk("rst_edata", 32'(egress_port_tdata), 32'd0);
        chk("rst_tready", 32'(ingress_port_tready), 32'd0);
        chk("rst_readdata", 32'(readdata), 32'd0);
        reset = 1'b0;
        av_read("reg0_reset", 8'h00, 8'h0F);
        av_read("reg1_reset", 8'h01, 8'h03);
        tick();
        chk("rd_idle_zero", 32'(readdata), 32'd0);

        // Round robin between ports 0 and 1 with one-cycle bubbles
        add_frame(0, 0, 3, 1);
        add_frame(1, 0, 3, 1);
        add_frame(0, 1, 3, 1);
        add_frame(1, 1, 3, 1);
        run_until_empty("rr", 40, cyc);
        chk("rr_cycles", 32'(cyc), 32'd16);
        av_read("reg1_after_rr", 8'h01, 8'h01);

        // Port 2 under toggling egress backpressure
        add_frame(2, 2, 3, 1);
        toggle_rdy = 1'b1;
        run_until_empty("toggle", 30, cyc);
        toggle_rdy = 1'b0;
        chk("toggle_src_drained", 32'(src_q[2].size()), 32'd0);

        // Enable mask excludes port 0
        av_write(8'h00, 8'h0E);
        av_read("reg0_mask", 8'h00, 8'h0E);
        add_frame(0, 3, 3, 0);
        add_frame(3, 3, 3, 1);
        run_until_empty("mask", 20, cyc);
        repeat (6) tick();
        chk("mask_port0_held", 32'(src_q[0].size()), 32'd3);
        src_q[0].delete();
        av_write(8'h00, 8'h0F);

        // Disable port 1 mid-frame: frame completes, no regrant
        add_frame(1, 4, 3, 1);
        add_frame(1, 5, 3, 0);
        tick();
        tick();
        av_write(8'h00, 8'h0D);
        run_until_empty("mid_disable", 10, cyc);
        repeat (6) tick();
        chk("disable_port1_held", 32'(src_q[1].size()), 32'd3);
        av_read("reg0_0d", 8'h00, 8'h0D);
        src_q[1].delete();
        av_write(8'h00, 8'h0F);

        // Reset in the middle of a port 1 frame
        add_frame(1, 5, 3, 1);
        tick();
        tick();
        chk("pre_reset_remaining", 32'(sb.size()), 32'd2);
        add_frame(0, 6, 3, 0);
        reset = 1'b1;
        #1;
        chk("mid_rst_evalid", 32'(egress_port_tvalid), 32'd0);
        chk("mid_rst_elast", 32'(egress_port_tlast), 32'd0);
        chk("mid_rst_edata", 32'(egress_port_tdata), 32'd0);
        chk("mid_rst_tready", 32'(ingress_port_tready), 32'd0);
        sb.delete();
        for (int b = 0; b < 3; b++) sb.push_back(mk(0, 6, b, (b == 2)));
        sb.push_back(mk(1, 5, 1, 1'b0));
        sb.push_back(mk(1, 5, 2, 1'b1));
        tick();
        tick();
        reset = 1'b0;
        run_until_empty("after_reset", 20, cyc);

        // Granted port stalls mid-frame; grant is held
        add_frame(2, 7, 3, 1);
        tick();
        tick();
        src_pause[2] = 1'b1;
        add_frame(0, 8, 2, 1);
        tick();
        chk("stall_evalid", 32'(s_evalid), 32'd0);
        chk("stall_hold", 32'(s_tready), 32'h4);
        av_read("reg1_grant", 8'h01, 8'h82);
        chk("stall_evalid2", 32'(s_evalid), 32'd0);
        src_pause[2] = 1'b0;
        run_until_empty("stall", 20, cyc);

        // Register map corner cases
        av_write(8'h01, 8'hFF);
        av_read("reg1_ro", 8'h01, 8'h00);
        av_write(8'h10, 8'h00);
        av_read("reg0_keep", 8'h00, 8'h0F);
        av_read("undef_addr", 8'h09, 8'h00);
`ifdef EGRESS_ARBITER_STATS_EN
        av_write(8'h08, 8'h00);
        av_read("cnt_clr0", 8'h04, 8'h00);
        for (int f = 0; f < 257; f++) add_frame(0, f % 16, 1, 1);
        run_until_empty("stats", 700, cyc);
        av_read("cnt_wrap", 8'h04, 8'h01);
        av_read("cnt_port1", 8'h05, 8'h00);
        av_write(8'h08, 8'h00);
        av_read("cnt_cleared", 8'h04, 8'h00);
`else
        av_read("stats_off", 8'h04, 8'h00);
        av_write(8'h04, 8'hAA);
        av_write(8'h08, 8'h55);
        av_read("stats_off_wr", 8'h04, 8'h00);
`endif
        tick();
        chk("rd_idle_end", 32'(readdata), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
